mc_rfr_sched: RTL and testbench

SDRAM refresh scheduler for the memory controller. It divides `clk` into refresh intervals and keeps a saturating count of owed refresh rounds. For each round it requests the main sequencer to issue `rfr_burst+1` auto-refresh commands to every SDRAM-populated chip select. It drives the `rfr_ack`/`cs_need_rfr` handshake that the pad interface uses to steer `mc_cs_` during refresh.

---
 rtl/mc_rfr_sched.sv | 160 ++++++++++++++++
 tb/tb_mc_rfr_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_rfr_sched.sv
// SDRAM refresh scheduler: divides clk into refresh intervals, counts owed
// refresh rounds and hands them to the main sequencer one round at a time.
module mc_rfr_sched #(
  parameter int PS_W   = 8,
  parameter int INT_W  = 4,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [PS_W-1:0]   rfr_ps_val,
  input  logic [INT_W-1:0]  rfr_int,
  input  logic [2:0]        rfr_burst,
  input  logic [7:0]        cs_sdram,
  input  logic              rfr_ack,
  input  logic              ovf_clr,
  output logic              rfr_req,
  output logic [7:0]        cs_need_rfr,
  output logic [PEND_W-1:0] rfr_pend,
  output logic              rfr_ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q, state_d;
  logic [PS_W-1:0]   ps_cnt_q, ps_cnt_d;
  logic [INT_W-1:0]  int_cnt_q, int_cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [7:0]        cs_need_q, cs_need_d;

  logic tick;
  logic expiry;
  logic rfr_due;
  logic round_done;
  logic ovf_set;

  // Interval timing and owed-round bookkeeping.
  // NOTE: every always_comb output gets a default assignment first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    tick       = (ps_cnt_q == '0);
    expiry     = tick && (int_cnt_q == '0);
    rfr_due    = expiry && (cs_sdram != 8'h00);
    round_done = (state_q == REQ) && rfr_ack && (bcnt_q == 3'd0);

    ps_cnt_d  = tick ? rfr_ps_val : ps_cnt_q - 1'b1;
    int_cnt_d = int_cnt_q;
    if (expiry) begin
      int_cnt_d = rfr_int;
    end else if (tick) begin
      int_cnt_d = int_cnt_q - 1'b1;
    end

    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (rfr_due && !round_done) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (round_done && !rfr_due) begin
      pend_d = pend_q - 1'b1;
    end

    if (!init_done) begin
      ps_cnt_d  = rfr_ps_val;
      int_cnt_d = rfr_int;
      pend_d    = '0;
      ovf_set   = 1'b0;
    end

    // A lost expiry takes priority over a clear in the same cycle.
    ovf_d = ovf_set || (ovf_q && !ovf_clr);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pend_q != '0) state_d = REQ;
      REQ:     if (round_done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!init_done) begin
      state_d = IDLE;
    end
  end

  // Round-scoped registers: chip-select mask and remaining burst commands.
  always_comb begin
    cs_need_d = cs_need_q;
    bcnt_d    = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          cs_need_d = cs_sdram;
          bcnt_d    = rfr_burst;
        end
      end
      REQ: begin
        if (rfr_ack) begin
          if (bcnt_q != 3'd0) begin
            bcnt_d = bcnt_q - 3'd1;
          end else begin
            cs_need_d = 8'h00;
          end
        end
      end
      default: begin
        cs_need_d = 8'h00;
        bcnt_d    = 3'd0;
      end
    endcase
    if (!init_done) begin
      cs_need_d = 8'h00;
      bcnt_d    = 3'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt_q  <= rfr_ps_val;
      int_cnt_q <= rfr_int;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      bcnt_q    <= 3'd0;
      cs_need_q <= 8'h00;
    end else begin
      ps_cnt_q  <= ps_cnt_d;
      int_cnt_q <= int_cnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      bcnt_q    <= bcnt_d;
      cs_need_q <= cs_need_d;
    end
  end

  assign rfr_req     = (state_q == REQ);
  assign cs_need_rfr = cs_need_q;
  assign rfr_pend    = pend_q;
  assign rfr_ovf     = ovf_q;

endmodule

// File: tb/tb_mc_rfr_sched.sv
// Bench for mc_rfr_sched: directed scenarios plus random traffic, all checked
// cycle by cycle against an interval/round-level reference model.
module tb_mc_rfr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic [7:0] rfr_ps_val;
  logic [3:0] rfr_int;
  logic [2:0] rfr_burst;
  logic [7:0] cs_sdram;
  logic       rfr_ack;
  logic       ovf_clr;
  logic       rfr_req;
  logic [7:0] cs_need_rfr;
  logic [2:0] rfr_pend;
  logic       rfr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owed rounds, sticky overflow, current round and the
  // number of clocks since enable (expiry every N clocks, last one of each N).
  int         m_pend, m_left, m_cnt, m_n;
  bit         m_ovf, m_round;
  logic [7:0] m_cs;

  always #5 clk = ~clk;

  mc_rfr_sched #(.PS_W(8), .INT_W(4), .PEND_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .rfr_ps_val  (rfr_ps_val),
    .rfr_int     (rfr_int),
    .rfr_burst   (rfr_burst),
    .cs_sdram    (cs_sdram),
    .rfr_ack     (rfr_ack),
    .ovf_clr     (ovf_clr),
    .rfr_req     (rfr_req),
    .cs_need_rfr (cs_need_rfr),
    .rfr_pend    (rfr_pend),
    .rfr_ovf     (rfr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit expiry, done, inc, lost;
    int old_pend;
    if (rst || !init_done) begin
      m_pend  = 0;
      m_round = 0;
      m_left  = 0;
      m_cs    = 8'h00;
      m_cnt   = 0;
      m_n     = (int'(rfr_ps_val) + 1) * (int'(rfr_int) + 1);
      m_ovf   = rst ? 1'b0 : (m_ovf && !ovf_clr);
    end else begin
      expiry   = (m_cnt % m_n) == (m_n - 1);
      m_cnt++;
      done     = m_round && rfr_ack && (m_left == 1);
      inc      = expiry && (cs_sdram != 8'h00);
      lost     = inc && !done && (m_pend == 7);
      old_pend = m_pend;
      if (inc && !done && m_pend < 7) m_pend++;
      else if (done && !inc) m_pend--;
      if (m_round) begin
        if (rfr_ack) begin
          m_left--;
          if (m_left == 0) begin
            m_round = 0;
            m_cs    = 8'h00;
          end
        end
      end else if (old_pend != 0) begin
        m_round = 1;
        m_left  = int'(rfr_burst) + 1;
        m_cs    = cs_sdram;
      end
      m_ovf = lost || (m_ovf && !ovf_clr);
    end
  endtask

  // One clock: advance the model with the inputs now applied, then compare.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("m_req",  rfr_req,     m_round);
    check("m_cs",   cs_need_rfr, m_cs);
    check("m_pend", rfr_pend,    m_pend);
    check("m_ovf",  rfr_ovf,     m_ovf);
  endtask

  task automatic do_reset(input logic [7:0] ps, input logic [3:0] iv, input logic [7:0] cs,
                          input logic [2:0] burst);
    rst        = 1'b1;
    init_done  = 1'b0;
    rfr_ps_val = ps;
    rfr_int    = iv;
    cs_sdram   = cs;
    rfr_burst  = burst;
    rfr_ack    = 1'b0;
    ovf_clr    = 1'b0;
    cyc();
    cyc();
    rst       = 1'b0;
    init_done = 1'b1;
  endtask

  initial begin
    m_ovf = 1'b0;

    // Enable timing: N = 4*2 = 8.
    do_reset(8'd3, 4'd1, 8'h05, 3'd2);
    check("rst_req",  rfr_req, 0);
    check("rst_pend", rfr_pend, 0);
    check("rst_ovf",  rfr_ovf, 0);
    check("rst_cs",   cs_need_rfr, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("en_req_early", rfr_req, 0);
      check("en_pend", rfr_pend, (k == 8) ? 1 : 0);
    end
    cyc();
    check("en_req", rfr_req, 1);
    check("en_cs",  cs_need_rfr, 8'h05);

    // Three-command burst with idle gaps between acks.
    for (int a = 1; a <= 3; a++) begin
      rfr_ack = 1'b1;
      cyc();
      rfr_ack = 1'b0;
      check("burst_req", rfr_req, (a < 3) ? 1 : 0);
      if (a < 3) cyc();
    end
    check("burst_pend", rfr_pend, 0);
    check("burst_cs",   cs_need_rfr, 0);

    // Backlog and saturation: expiry every clock.
    do_reset(8'd0, 4'd0, 8'hFF, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("sat_pend", rfr_pend, (k < 7) ? k : 7);
      check("sat_ovf",  rfr_ovf, (k >= 8) ? 1 : 0);
    end
    repeat (3) begin
      cyc();
      check("sat_ovf_hold", rfr_ovf, 1);
    end

    // Mask further expiries mid-round; the latched mask must hold.
    cs_sdram = 8'h00;
    cyc();
    check("stab_cs",  cs_need_rfr, 8'hFF);
    check("stab_req", rfr_req, 1);

    for (int r = 0; r < 2; r++) begin
      rfr_ack = 1'b1;
      cyc();
      rfr_ack = 1'b0;
      check("drain_req_lo", rfr_req, 0);
      check("drain_pend",   rfr_pend, 6 - r);
      cyc();
      check("drain_req_hi", rfr_req, 1);
    end

    // Abort mid-round: disabled values next cycle, overflow retained.
    init_done = 1'b0;
    cyc();
    check("abort_req",  rfr_req, 0);
    check("abort_cs",   cs_need_rfr, 0);
    check("abort_pend", rfr_pend, 0);
    check("abort_ovf",  rfr_ovf, 1);
    init_done = 1'b1;
    ovf_clr   = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("ovf_clr", rfr_ovf, 0);

    // Expiry coinciding with the final ack.
    do_reset(8'd0, 4'd0, 8'h01, 3'd0);
    cyc();
    cyc();
    check("sim_pend0", rfr_pend, 2);
    check("sim_req0",  rfr_req, 1);
    rfr_ack = 1'b1;
    cyc();
    rfr_ack = 1'b0;
    check("sim_pend", rfr_pend, 2);
    check("sim_req_lo", rfr_req, 0);
    cyc();
    check("sim_req_hi", rfr_req, 1);

    // Masked expiries: N = 4, 14 clocks covers three expiries.
    do_reset(8'd1, 4'd1, 8'h00, 3'd1);
    for (int k = 0; k < 14; k++) begin
      cyc();
      check("mask_pend", rfr_pend, 0);
      check("mask_ovf",  rfr_ovf, 0);
      check("mask_req",  rfr_req, 0);
    end

    // Random traffic; reload values change only while disabled.
    do_reset(8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'h3C, 3'd1);
    for (int k = 0; k < 3000; k++) begin
      if (init_done && ($urandom % 150) == 0) begin
        init_done  = 1'b0;
        rfr_ps_val = 8'($urandom_range(0, 3));
        rfr_int    = 4'($urandom_range(0, 3));
      end else if (!init_done && ($urandom % 2) == 0) begin
        init_done = 1'b1;
      end
      if (($urandom % 40) == 0) begin
        cs_sdram = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      end
      rfr_burst = 3'($urandom_range(0, 3));
      rfr_ack   = (($urandom % 3) == 0);
      ovf_clr   = init_done && (($urandom % 40) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
